// File: rtl/voice_pkg.sv
// Shared sizing, types and helpers for the voice allocator.
package voice_pkg;

    localparam int unsigned NUM_VOICES     = 3;
    localparam int unsigned NOTE_WIDTH     = 6;
    localparam int unsigned DURATION_WIDTH = 6;
    localparam int unsigned AGE_WIDTH      = 2;
    localparam int unsigned IDX_WIDTH      = 2;

    typedef logic [NOTE_WIDTH-1:0]     note_t;
    typedef logic [DURATION_WIDTH-1:0] dur_t;
    typedef logic [AGE_WIDTH-1:0]      age_t;
    typedef logic [IDX_WIDTH-1:0]      idx_t;
    typedef logic [NUM_VOICES-1:0]     voice_mask_t;

    // Ages saturate here rather than at the full counter range.
    localparam age_t AGE_MAX = 2'd2;

    function automatic idx_t popcount(input voice_mask_t m);
        idx_t c;
        c = '0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            c = c + idx_t'(m[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/voice_allocator_if.sv
// Note-event handshake between the upstream reader and the allocator.
interface voice_allocator_if;
    import voice_pkg::*;

    logic  note_valid;
    note_t note_in;
    dur_t  duration_in;
    logic  note_ready;

    modport master (output note_valid, note_in, duration_in, input note_ready);
    modport slave  (input note_valid, note_in, duration_in, output note_ready);

endinterface

// File: rtl/voice_select.sv
// Combinational voice pick: lowest-index free voice, or with
// VOICE_ALLOCATOR_STEAL_EN the oldest busy voice when none is free.
module voice_select
    import voice_pkg::*;
(
    input  voice_mask_t busy,
`ifdef VOICE_ALLOCATOR_STEAL_EN
    input  age_t        ages [NUM_VOICES],
`endif
    output logic        pick_valid,
    output idx_t        pick_idx
);

    logic free_found;
    idx_t free_idx;
`ifdef VOICE_ALLOCATOR_STEAL_EN
    idx_t oldest_idx;
    age_t best_age;
`endif

    // Priority pick of the free voice and, when stealing, the oldest one.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            if (!busy[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = idx_t'(i);
            end
        end
`ifdef VOICE_ALLOCATOR_STEAL_EN
        oldest_idx = '0;
        best_age   = ages[0];
        for (int unsigned i = 1; i < NUM_VOICES; i++) begin
            if (ages[i] > best_age) begin
                best_age   = ages[i];
                oldest_idx = idx_t'(i);
            end
        end
        pick_valid = 1'b1;
        pick_idx   = free_found ? free_idx : oldest_idx;
`else
        pick_valid = free_found;
        pick_idx   = free_idx;
`endif
    end

endmodule

// File: rtl/voice_allocator.sv
// Voice allocator: hands note events to a pool of note players.
// Optional feature macro: VOICE_ALLOCATOR_STEAL_EN (steal oldest voice when full).
module voice_allocator
    import voice_pkg::*;
(
    input  logic                                   clk,
    input  logic                                   reset,
    voice_allocator_if.slave                       bus,
    input  voice_mask_t                            note_done,
    input  logic                                   flush,
    output voice_mask_t                            voice_load,
    output logic [NUM_VOICES*NOTE_WIDTH-1:0]       voice_note,
    output logic [NUM_VOICES*DURATION_WIDTH-1:0]   voice_duration,
    output voice_mask_t                            busy,
    output idx_t                                   active_count
);

    age_t        ages [NUM_VOICES];
    logic        pick_valid;
    idx_t        pick_idx;
    logic        accept;
    voice_mask_t load_mask;

    voice_select u_select (
        .busy       (busy),
`ifdef VOICE_ALLOCATOR_STEAL_EN
        .ages       (ages),
`endif
        .pick_valid (pick_valid),
        .pick_idx   (pick_idx)
    );

    // Handshake and per-voice load decode; ready never depends on note_valid.
    always_comb begin
        bus.note_ready = !flush && pick_valid;
        accept         = bus.note_valid && bus.note_ready;
        load_mask      = '0;
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            load_mask[v] = accept && (pick_idx == idx_t'(v));
        end
        active_count = popcount(busy);
    end

    // Voice state: a load beats a same-edge note_done; flush releases everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy           <= '0;
            voice_load     <= '0;
            voice_note     <= '0;
            voice_duration <= '0;
            for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                ages[v] <= '0;
            end
        end else if (flush) begin
            busy       <= '0;
            voice_load <= '0;
            for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                ages[v] <= '0;
            end
        end else begin
            voice_load <= load_mask;
            for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                if (load_mask[v]) begin
                    busy[v]                                   <= 1'b1;
                    ages[v]                                   <= '0;
                    voice_note[v*NOTE_WIDTH +: NOTE_WIDTH]         <= bus.note_in;
                    voice_duration[v*DURATION_WIDTH +: DURATION_WIDTH] <= bus.duration_in;
                end else if (note_done[v] && busy[v]) begin
                    busy[v] <= 1'b0;
                    ages[v] <= '0;
                end else if (busy[v] && accept && ages[v] != AGE_MAX) begin
                    ages[v] <= ages[v] + 1'b1;
                end
            end
        end
    end

endmodule
